instruction_sequencer: RTL and testbench

//  Parametrised successor to the 4004 instruction decoder. Generates its own
//  8-phase instruction cycle (A1..X3) gated by a step enable, and latches OPR/OPA from a

---
 rtl/instruction_sequencer.sv | 176 +++++++++++++++++
 tb/tb_instruction_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Generates the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3),
//   latches the OPR/OPA opcode fragments and the optional second-cycle
//   operand, tracks single/double-cycle instructions through a class table,
//   evaluates the JCN/ISZ jump condition and pulses instr_valid once per
//   completed instruction.
//
// Handshake: instr_valid is a one-clock strobe with no back-pressure. While it
//   is high, opr/opa/opd/jump hold the completed record. They stay stable
//   until the next M1.
//
// Ports
//   sysclk      system clock; all state changes on the rising edge
//   poc_n       asynchronous active-low power-on clear
//   step        phase advance enable; 0 freezes all state
//   data_in     ROM/data bus input fragment
//   acc_zero    ACC == 0 from the ALU
//   cy          carry from the ALU
//   test_n      conditioned TEST pin, active low
//   add_zero    ISZ adder result == 0
//   phase       one-hot {X3,X2,X1,M2,M1,A3,A2,A1}
//   sync        A1 marker (phase[0])
//   sc          1 = first (or only) cycle, 0 = second cycle (FSM state)
//   opr / opa   latched opcode high / low fragment
//   opd         second-cycle operand {M1 fragment, M2 fragment}
//   jump        condition result of the last JCN/ISZ
//   data_out    opa while data_oe, else 0
//   data_oe     bus drive enable
//   instr_valid one-clock pulse: instruction record complete
module instruction_sequencer #(
  parameter int          DATA_W    = 4,
  parameter logic [15:0] DC_MASK   = 16'h00B2,
  parameter logic [15:0] PAIR_MASK = 16'h000C,
  parameter logic [3:0]  COND_OPR  = 4'h1,
  parameter logic [3:0]  ISZ_OPR   = 4'h7,
  parameter logic [15:0] OE_MASK   = 16'h3030
) (
  input  logic                sysclk,
  input  logic                poc_n,
  input  logic                step,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                acc_zero,
  input  logic                cy,
  input  logic                test_n,
  input  logic                add_zero,
  output logic [7:0]          phase,
  output logic                sync,
  output logic                sc,
  output logic [DATA_W-1:0]   opr,
  output logic [DATA_W-1:0]   opa,
  output logic [2*DATA_W-1:0] opd,
  output logic                jump,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_oe,
  output logic                instr_valid
);

  // Phase bit positions inside the one-hot ring.
  localparam int PH_M1 = 3;
  localparam int PH_M2 = 4;
  localparam int PH_X2 = 6;
  localparam int PH_X3 = 7;

  typedef enum logic {
    CYC_SECOND = 1'b0,
    CYC_FIRST  = 1'b1
  } cyc_e;

  cyc_e                state_q, state_d;
  logic [7:0]          phase_q;
  logic [DATA_W-1:0]   opr_q, opa_q;
  logic [2*DATA_W-1:0] opd_q;
  logic                jump_q, jump_d;
  logic                valid_q, valid_d;

  logic [3:0] code;
  logic       first;
  logic       dbl;
  logic       at_x3;
  logic       cond;

  // Only the low nibble classifies the instruction; wider buses carry
  // their upper bits through undecoded.
  assign code  = opr_q[3:0];
  assign first = (state_q == CYC_FIRST);
  assign dbl   = DC_MASK[code] | (PAIR_MASK[code] & ~opa_q[0]);
  assign at_x3 = phase_q[PH_X3] & step;
  assign cond  = opa_q[3] ^ ((opa_q[2] & acc_zero) |
                             (opa_q[1] & cy) |
                             (opa_q[0] & ~test_n));

  // Cycle FSM, jump condition and end-of-instruction strobe. Everything
  // here reads the pre-edge opr/opa, so the X3 decisions see the opcode
  // fragments latched during this cycle.
  always_comb begin
    state_d = state_q;
    jump_d  = jump_q;
    valid_d = 1'b0;
    if (at_x3) begin
      case (state_q)
        CYC_FIRST: begin
          if (dbl) begin
            state_d = CYC_SECOND;
          end else begin
            valid_d = 1'b1;
          end
          if (code == COND_OPR) begin
            jump_d = cond;
          end else if (code == ISZ_OPR) begin
            jump_d = ~add_zero;
          end else begin
            jump_d = 1'b0;
          end
        end
        CYC_SECOND: begin
          state_d = CYC_FIRST;
          valid_d = 1'b1;
        end
        default: state_d = CYC_FIRST;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state_q <= CYC_FIRST;
      jump_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      jump_q  <= jump_d;
      // Recomputed every clock so the strobe lasts exactly one clock,
      // even when step drops right after X3.
      valid_q <= valid_d;
    end
  end

  // Phase ring and fragment latches.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      phase_q <= 8'h01;
      opr_q   <= '0;
      opa_q   <= '0;
      opd_q   <= '0;
    end else if (step) begin
      phase_q <= {phase_q[6:0], phase_q[7]};
      if (phase_q[PH_M1]) begin
        if (first) begin
          opr_q <= data_in;
          opd_q <= '0;  // single-cycle records report a zero operand
        end else begin
          opd_q[2*DATA_W-1:DATA_W] <= data_in;
        end
      end
      if (phase_q[PH_M2]) begin
        if (first) begin
          opa_q <= data_in;
        end else begin
          opd_q[DATA_W-1:0] <= data_in;
        end
      end
    end
  end

  assign phase       = phase_q;
  assign sync        = phase_q[0];
  assign sc          = first;
  assign opr         = opr_q;
  assign opa         = opa_q;
  assign opd         = opd_q;
  assign jump        = jump_q;
  assign instr_valid = valid_q;
  assign data_oe     = phase_q[PH_X2] & step & first & OE_MASK[code];
  assign data_out    = data_oe ? opa_q : '0;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer. Two instances share one stimulus stream:
// u4 (DATA_W=4) sees the low nibble of every bus fragment, and u8 (DATA_W=8)
// sees the full byte. Each expected record is packed as
// {oe, jump, opr8, opa8, m1_8, m2_8} and pushed once per instance queue. The
// monitors derive the width-specific view from that record.
module tb_instruction_sequencer;

  localparam int REC_W = 34;

  logic       sysclk = 1'b0;
  logic       poc_n;
  logic       step;
  logic [7:0] data_in;
  logic       acc_zero, cy, test_n, add_zero;

  logic [7:0]  phase4, phase8;
  logic        sync4, sync8, sc4, sc8;
  logic [3:0]  opr4, opa4, data_out4;
  logic [7:0]  opr8, opa8, data_out8, opd4;
  logic [15:0] opd8;
  logic        jump4, jump8, data_oe4, data_oe8, iv4, iv8;

  int checks = 0;
  int errors = 0;

  logic [REC_W-1:0] exp_q4[$];
  logic [REC_W-1:0] exp_q8[$];
  logic [REC_W-1:0] e4, e8;
  int oe_cnt4 = 0;
  int oe_cnt8 = 0;

  instruction_sequencer #(.DATA_W(4)) u4 (
    .sysclk(sysclk), .poc_n(poc_n), .step(step), .data_in(data_in[3:0]),
    .acc_zero(acc_zero), .cy(cy), .test_n(test_n), .add_zero(add_zero),
    .phase(phase4), .sync(sync4), .sc(sc4), .opr(opr4), .opa(opa4),
    .opd(opd4), .jump(jump4), .data_out(data_out4), .data_oe(data_oe4),
    .instr_valid(iv4)
  );

  instruction_sequencer #(.DATA_W(8)) u8 (
    .sysclk(sysclk), .poc_n(poc_n), .step(step), .data_in(data_in),
    .acc_zero(acc_zero), .cy(cy), .test_n(test_n), .add_zero(add_zero),
    .phase(phase8), .sync(sync8), .sc(sc8), .opr(opr8), .opa(opa8),
    .opd(opd8), .jump(jump8), .data_out(data_out8), .data_oe(data_oe8),
    .instr_valid(iv8)
  );

  // ---------------- clock ----------------
  always #5 sysclk = ~sysclk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One 8-phase cycle from A1. With tog set, every step=1 clock is followed
  // by a step=0 clock, during which nothing may move.
  task automatic run_cycle(input logic [7:0] b_m1, input logic [7:0] b_m2, input bit tog);
    logic [7:0] one;
    logic [7:0] exp_ph;
    one = 8'h01;
    for (int k = 0; k < 8; k++) begin
      data_in = (k == 3) ? b_m1 : ((k == 4) ? b_m2 : 8'h00);
      step = 1'b1;
      @(posedge sysclk); #1;
      exp_ph = one << ((k + 1) % 8);
      chk("phase4", {24'h0, phase4}, {24'h0, exp_ph});
      chk("phase8", {24'h0, phase8}, {24'h0, exp_ph});
      if (tog) begin
        step = 1'b0;
        @(posedge sysclk); #1;
        chk("phase_hold", {24'h0, phase4}, {24'h0, exp_ph});
      end
    end
  endtask

  task automatic run_instr(input logic [7:0] i_opr, input logic [7:0] i_opa,
                           input logic [7:0] m1, input logic [7:0] m2,
                           input bit dbl, input bit jmp, input bit oe, input bit tog);
    logic [REC_W-1:0] rec;
    rec = {oe, jmp, i_opr, i_opa, (dbl ? m1 : 8'h00), (dbl ? m2 : 8'h00)};
    exp_q4.push_back(rec);
    exp_q8.push_back(rec);
    run_cycle(i_opr, i_opa, tog);
    chk("sc4_after_c1", {31'h0, sc4}, {31'h0, ~dbl});
    chk("sc8_after_c1", {31'h0, sc8}, {31'h0, ~dbl});
    if (dbl) begin
      run_cycle(m1, m2, tog);
      chk("sc4_after_c2", {31'h0, sc4}, 32'h1);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge sysclk) begin
    if (!poc_n) begin
      oe_cnt4 = 0;
      oe_cnt8 = 0;
    end else begin
      if (data_oe4) begin
        oe_cnt4++;
        if (exp_q4.size() == 0) chk("oe4_unexpected", 32'h1, 32'h0);
        else chk("data_out4", {28'h0, data_out4}, {28'h0, exp_q4[0][19:16]});
      end
      if (data_oe8) begin
        oe_cnt8++;
        if (exp_q8.size() == 0) chk("oe8_unexpected", 32'h1, 32'h0);
        else chk("data_out8", {24'h0, data_out8}, {24'h0, exp_q8[0][23:16]});
      end
      if (iv4) begin
        if (exp_q4.size() == 0) begin
          chk("iv4_unexpected", 32'h1, 32'h0);
        end else begin
          e4 = exp_q4.pop_front();
          chk("opr4", {28'h0, opr4}, {28'h0, e4[27:24]});
          chk("opa4", {28'h0, opa4}, {28'h0, e4[19:16]});
          chk("opd4", {24'h0, opd4}, {24'h0, e4[11:8], e4[3:0]});
          chk("jump4", {31'h0, jump4}, {31'h0, e4[32]});
          chk("oe_cnt4", oe_cnt4, {31'h0, e4[33]});
        end
        oe_cnt4 = 0;
      end
      if (iv8) begin
        if (exp_q8.size() == 0) begin
          chk("iv8_unexpected", 32'h1, 32'h0);
        end else begin
          e8 = exp_q8.pop_front();
          chk("opr8", {24'h0, opr8}, {24'h0, e8[31:24]});
          chk("opa8", {24'h0, opa8}, {24'h0, e8[23:16]});
          chk("opd8", {16'h0, opd8}, {16'h0, e8[15:0]});
          chk("jump8", {31'h0, jump8}, {31'h0, e8[32]});
          chk("oe_cnt8", oe_cnt8, {31'h0, e8[33]});
        end
        oe_cnt8 = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    poc_n = 1'b0; step = 1'b0; data_in = 8'h00;
    acc_zero = 1'b0; cy = 1'b0; test_n = 1'b1; add_zero = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 poc_n = 1'b1;

    // JUN first cycle interrupted by reset while sitting in M2.
    for (int k = 0; k < 4; k++) begin
      data_in = (k == 3) ? 8'h04 : 8'h00;
      step = 1'b1;
      @(posedge sysclk); #1;
    end
    chk("pre_reset_phase_m2", {24'h0, phase4}, 32'h10);
    data_in = 8'h03;
    poc_n = 1'b0;
    #1;
    chk("rst_phase4", {24'h0, phase4}, 32'h01);
    chk("rst_phase8", {24'h0, phase8}, 32'h01);
    chk("rst_sync", {31'h0, sync4}, 32'h1);
    chk("rst_sc", {31'h0, sc4}, 32'h1);
    chk("rst_opr", {28'h0, opr4}, 32'h0);
    chk("rst_opa", {28'h0, opa4}, 32'h0);
    chk("rst_opd", {24'h0, opd4}, 32'h0);
    chk("rst_jump", {31'h0, jump4}, 32'h0);
    chk("rst_data_oe", {31'h0, data_oe4}, 32'h0);
    chk("rst_iv", {31'h0, iv4}, 32'h0);
    // step held high across an edge in reset: reset must win.
    @(posedge sysclk); #1;
    chk("rst_hold_phase", {24'h0, phase4}, 32'h01);
    poc_n = 1'b1;
    step = 1'b0;
    @(posedge sysclk); #1;

    // Fresh walk after reset: a NOP, single cycle, only record expected.
    run_instr(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

    // JUN 4/3, operand 5,A: double cycle, drives OPA at X2.
    run_instr(8'h04, 8'h03, 8'h05, 8'h0A, 1, 0, 1, 0);

    // JCN: OPA=0100 with ACC==0 -> jump; OPA=1100 inverts -> no jump.
    acc_zero = 1'b1;
    run_instr(8'h01, 8'h04, 8'h02, 8'h03, 1, 1, 0, 0);
    run_instr(8'h01, 8'h0C, 8'h07, 8'h0E, 1, 0, 0, 0);
    // JCN OPA=0011, only TEST active -> jump.
    acc_zero = 1'b0; cy = 1'b0; test_n = 1'b0;
    run_instr(8'h01, 8'h03, 8'h01, 8'h01, 1, 1, 0, 0);
    test_n = 1'b1;

    // ISZ: adder non-zero -> jump, adder zero -> no jump.
    add_zero = 1'b0;
    run_instr(8'h07, 8'h05, 8'h09, 8'h01, 1, 1, 0, 0);
    add_zero = 1'b1;
    run_instr(8'h07, 8'h02, 8'h00, 8'h04, 1, 0, 0, 0);

    // FIM pair: OPA odd (SRC) single, OPA even double.
    run_instr(8'h02, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0);
    run_instr(8'h02, 8'h00, 8'h0C, 8'h03, 1, 0, 0, 0);

    // LDM at full rate, then with step toggling every clock.
    run_instr(8'h0D, 8'h06, 8'h00, 8'h00, 0, 0, 1, 0);
    run_instr(8'h0D, 8'h06, 8'h00, 8'h00, 0, 0, 1, 1);

    // BBL: single cycle, drives OPA.
    run_instr(8'h0C, 8'h09, 8'h00, 8'h00, 0, 0, 1, 0);

    // Wide opcode 8'hA4: decoded as code 4 (double), upper bits kept.
    run_instr(8'hA4, 8'h3B, 8'h5C, 8'h7D, 1, 0, 1, 0);

    step = 1'b0;
    data_in = 8'h00;
    repeat (3) @(posedge sysclk);
    #1;
    chk("queue4_drained", exp_q4.size(), 32'h0);
    chk("queue8_drained", exp_q8.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
